// File: rtl/anc_pkg.sv
// Shared definitions for the ANC sequencer and datapath: state encoding,
// strobe bundle, and frame-length arithmetic.
package anc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_FILTER,
    ST_ERR,
    ST_UPDATE,
    ST_OUT
  } anc_state_e;

  typedef struct packed {
    logic read_main;
    logic read_sub;
    logic write_new_mem;
    logic clr_i;
    logic inc_i;
    logic inc_ptr;
    logic compute_error;
    logic weight_update;
    logic update_mem;
    logic write_output;
  } anc_strobes_t;

  // READ + ERR + OUT are single-cycle; FILTER and UPDATE are one cycle per tap.
  localparam int unsigned FRAME_FIXED_CYCLES = 3;

  function automatic int unsigned frame_len(input int unsigned fir_length);
    return 2 * fir_length + FRAME_FIXED_CYCLES;
  endfunction

  function automatic anc_strobes_t decode_strobes(input anc_state_e s);
    anc_strobes_t d;
    d = '0;
    case (s)
      ST_READ: begin
        d.read_main     = 1'b1;
        d.read_sub      = 1'b1;
        d.write_new_mem = 1'b1;
        d.clr_i         = 1'b1;
      end
      ST_FILTER: begin
        d.inc_i   = 1'b1;
        d.inc_ptr = 1'b1;
      end
      ST_ERR: begin
        d.compute_error = 1'b1;
        d.clr_i         = 1'b1;
      end
      ST_UPDATE: begin
        d.weight_update = 1'b1;
        d.update_mem    = 1'b1;
        d.inc_i         = 1'b1;
        d.inc_ptr       = 1'b1;
      end
      ST_OUT:  d.write_output = 1'b1;
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/anc_tap_counter.sv
// Tap index counter: synchronous clear, enable, wraps to 0 after the last tap
// and flags the last tap combinationally.
module anc_tap_counter #(
  parameter int unsigned FIR_LENGTH = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(FIR_LENGTH - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == LAST_TAP);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/anc_sequencer.sv
// Frame sequencer for the adaptive noise canceller: READ, FILTER taps, ERR,
// UPDATE taps, OUT, with Moore-registered strobes and a sticky overrun flag.
module anc_sequencer
  import anc_pkg::*;
#(
  parameter int unsigned FIR_LENGTH = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_sample,
  output logic             read_main,
  output logic             read_sub,
  output logic             write_new_mem,
  output logic             clr_i,
  output logic             inc_i,
  output logic             inc_ptr,
  output logic             compute_error,
  output logic             weight_update,
  output logic             update_mem,
  output logic             write_output,
  output logic [CNT_W-1:0] tap_idx,
  output logic             busy,
  output logic             overrun
);

  anc_state_e   r_state;
  anc_state_e   w_next;
  anc_strobes_t r_strb;
  logic         r_busy;
  logic         r_overrun;
  logic         w_tc;
  logic         w_cnt_en;
  logic         w_cnt_clr;

  anc_tap_counter #(
    .FIR_LENGTH(FIR_LENGTH),
    .CNT_W     (CNT_W)
  ) u_tap_counter (
    .i_clk(clk),
    .i_rst(rst),
    .i_clr(w_cnt_clr),
    .i_en (w_cnt_en),
    .o_cnt(tap_idx),
    .o_tc (w_tc)
  );

  // Counter is held at 0 outside the tap phases so each phase starts at tap 0.
  always_comb begin
    w_cnt_en  = (r_state == ST_FILTER) || (r_state == ST_UPDATE);
    w_cnt_clr = !w_cnt_en;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_WAIT;
      ST_WAIT: begin
        if (!start)            w_next = ST_IDLE;
        else if (start_sample) w_next = ST_READ;
      end
      ST_READ:   w_next = ST_FILTER;
      ST_FILTER: if (w_tc) w_next = ST_ERR;
      ST_ERR:    w_next = ST_UPDATE;
      ST_UPDATE: if (w_tc) w_next = ST_OUT;
      ST_OUT: begin
        if (start && start_sample) w_next = ST_READ;
        else if (start)            w_next = ST_WAIT;
        else                       w_next = ST_IDLE;
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  // Strobes and busy are registered from the next state so they track r_state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_strb    <= '0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_next;
      r_strb  <= decode_strobes(w_next);
      r_busy  <= !(w_next inside {ST_IDLE, ST_WAIT});
      if (r_state == ST_IDLE)
        r_overrun <= 1'b0;
      else if (start_sample && (r_state inside {ST_READ, ST_FILTER, ST_ERR, ST_UPDATE}))
        r_overrun <= 1'b1;
    end
  end

  assign read_main     = r_strb.read_main;
  assign read_sub      = r_strb.read_sub;
  assign write_new_mem = r_strb.write_new_mem;
  assign clr_i         = r_strb.clr_i;
  assign inc_i         = r_strb.inc_i;
  assign inc_ptr       = r_strb.inc_ptr;
  assign compute_error = r_strb.compute_error;
  assign weight_update = r_strb.weight_update;
  assign update_mem    = r_strb.update_mem;
  assign write_output  = r_strb.write_output;
  assign busy          = r_busy;
  assign overrun       = r_overrun;

endmodule

// File: doc/anc_sequencer.md
ANC_SEQUENCER -- requirements
Module: anc_sequencer

Interface
REQ-001 The block SHALL have parameter FIR_LENGTH, default 16, meaning the number of adaptive FIR taps sequenced per sample (legal range 2..256).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the tap_idx width (SHALL satisfy 2^CNT_W >= FIR_LENGTH).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  level enable; 1 = process samples, 0 = stop after the current frame.
REQ-006 start_sample  input  1  single-cycle sample strobe from the sampling timer.
REQ-007 read_main, read_sub  output  1 each  latch main/sub inputs into the datapath.
REQ-008 write_new_mem  output  1  write the new sub sample into the delay line.
REQ-009 clr_i  output  1  clear the datapath tap counter and accumulator.
REQ-010 inc_i, inc_ptr  output  1 each  advance the datapath tap counter and delay-line pointer.
REQ-011 compute_error  output  1  form error = main - FIR output.
REQ-012 weight_update, update_mem  output  1 each  update coefficient[tap_idx] and its memory word.
REQ-013 write_output  output  1  register the error as the block output.
REQ-014 tap_idx  output  CNT_W  current tap index.
REQ-015 busy  output  1  high whenever state is not IDLE or WAIT.
REQ-016 overrun  output  1  sticky flag: a sample strobe arrived while a frame was in progress.

Function
REQ-017 The FSM SHALL have the states IDLE, WAIT, READ, FILTER, ERR, UPDATE and OUT.
REQ-018 IDLE -> WAIT when start=1; WAIT -> READ on start_sample=1; WAIT -> IDLE when start=0.
REQ-019 READ SHALL last 1 cycle asserting read_main, read_sub, write_new_mem and clr_i, with tap_idx set to 0 on exit.
REQ-020 FILTER SHALL last exactly FIR_LENGTH cycles asserting inc_i and inc_ptr, with tap_idx stepping 0..FIR_LENGTH-1, one value per cycle.
REQ-021 ERR SHALL last 1 cycle asserting compute_error and clr_i, and SHALL reset tap_idx to 0.
REQ-022 UPDATE SHALL last exactly FIR_LENGTH cycles asserting weight_update, update_mem, inc_i and inc_ptr, with tap_idx stepping 0..FIR_LENGTH-1.
REQ-023 OUT SHALL last 1 cycle asserting write_output, then go to READ if start_sample=1 and start=1, else to WAIT if start=1, else to IDLE.
REQ-024 Latency: with the strobe sampled on edge t, write_output SHALL be high during cycle t+2*FIR_LENGTH+3, and a frame SHALL occupy 2*FIR_LENGTH+3 cycles.
REQ-025 tap_idx SHALL wrap from FIR_LENGTH-1 to 0 at each phase exit and SHALL never reach FIR_LENGTH.
REQ-026 All strobe outputs SHALL be Moore-decoded from state, glitch-free and registered-state based, and SHALL be 0 in IDLE and WAIT.
REQ-027 start_sample in READ, FILTER, ERR or UPDATE SHALL set overrun and SHALL be dropped, leaving the frame undisturbed.
REQ-028 start_sample in OUT SHALL be accepted and SHALL NOT set overrun.
REQ-029 start falling mid-frame SHALL complete the frame, including OUT, and then go to IDLE.
REQ-030 overrun SHALL clear only on reset or while in IDLE.

Reset
REQ-031 rst=1 SHALL asynchronously force state IDLE, tap_idx=0, overrun=0 and all strobes and busy to 0.
REQ-032 Reset mid-frame SHALL abandon the frame, and the first frame after reset release SHALL require start plus a new start_sample.

Structure
REQ-033 The state encoding and the frame-length constant (2*FIR_LENGTH+3) SHALL reside in the shared package anc_pkg, which the datapath also uses.
REQ-034 The tap counter SHALL be one sub-module, anc_tap_counter (clear, enable, terminal-count output at FIR_LENGTH-1), and the FSM SHALL use its terminal count for FILTER/UPDATE exit.

Verification
REQ-035 Reset, then start=1 with a strobe at edge 0 and FIR_LENGTH=16: READ at cycle 1, FILTER at cycles 2-17, ERR at 18, UPDATE at 19-34, write_output at 35, and exactly 16 inc_i pulses per phase.
REQ-036 Strobe at cycle 10 of the frame: overrun=1, no extra frame, and write_output still at cycle 35.
REQ-037 Strobe coincident with OUT: READ in the next cycle, overrun=0, and back-to-back frames 35 cycles apart.
REQ-038 start dropped at cycle 5: the frame completes with write_output at 35, then IDLE, and later strobes are ignored.
REQ-039 rst pulsed at cycle 20 (UPDATE): all outputs 0 immediately, tap_idx=0, and with start held high the next strobe restarts a full 35-cycle frame.
REQ-040 FIR_LENGTH=2: frame of 7 cycles with tap_idx sequence 0,1 in FILTER and in UPDATE.
